bicubic_sched: RTL and testbench

BICUBIC_SCHED -- requirements
Module: bicubic_sched

---
 rtl/bicubic_pkg.sv | 32 +++
 rtl/bicubic_frac_div.sv | 48 ++++
 rtl/bicubic_sched.sv | 184 ++++++++++++++++++
 tb/tb_bicubic_sched.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bicubic_pkg.sv
// bicubic_pkg: shared widths, image geometry, FSM states and the
// coordinate clamp used by the bicubic tap scheduler.
package bicubic_pkg;

  localparam int IMG_W  = 100;
  localparam int IMG_H  = 100;
  localparam int CRD_W  = 7;
  localparam int ADDR_W = 14;
  localparam int PH_W   = 8;

  typedef logic [CRD_W-1:0]  crd_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [3:0] {
    IDLE, SETUP, DIV, FETCH, LAUNCH,
    WAIT, WRITE, NEXT, FIN
  } state_t;

  // s is coordinate+1, so clamp(s-1) to [0, lim-1] without signed math
  function automatic crd_t clamp(
    input logic [8:0] s,
    input int         lim
  );
    if (s == 9'd0)
      return '0;
    else if (int'(s) > lim)
      return crd_t'(lim - 1);
    else
      return crd_t'(s - 9'd1);
  endfunction

endpackage

// File: rtl/bicubic_frac_div.sv
// bicubic_frac_div: 8-step restoring divider giving floor(num*256/den)
// for num < den; den == 0 yields 0.
module bicubic_frac_div
  import bicubic_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [CRD_W-1:0] num,
  input  logic [CRD_W-1:0] den,
  output logic [PH_W-1:0] q,
  output logic            valid
);

  logic [2:0]     r_cnt;
  crd_t           r_rem;
  logic [CRD_W:0] w_sh;
  logic           w_ge;
  crd_t           w_rem;

  // first quotient bit is produced in the start cycle itself
  assign w_sh  = {(start ? num : r_rem), 1'b0};
  assign w_ge  = (den != '0) && (w_sh >= {1'b0, den});
  assign w_rem = w_ge ? crd_t'(w_sh - {1'b0, den})
                      : w_sh[CRD_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_rem <= '0;
      q     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        r_cnt <= 3'd7;
        r_rem <= w_rem;
        q     <= {{(PH_W-1){1'b0}}, w_ge};
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 3'd1;
        r_rem <= w_rem;
        q     <= {q[PH_W-2:0], w_ge};
        valid <= (r_cnt == 3'd1);
      end
    end
  end

endmodule

// File: rtl/bicubic_sched.sv
// bicubic_sched: walks the target raster, derives source position and
// phase by DDA, fetches 4x4 taps into the engine and writes results.
module bicubic_sched
  import bicubic_pkg::*;
#(
  parameter int IMG_W       = bicubic_pkg::IMG_W,
  parameter int IMG_H       = bicubic_pkg::IMG_H,
  parameter int ENG_TIMEOUT = 0
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CRD_W-1:0]  h0,
  input  logic [CRD_W-1:0]  v0,
  input  logic [CRD_W-1:0]  sw,
  input  logic [CRD_W-1:0]  sh,
  input  logic [CRD_W-1:0]  tw,
  input  logic [CRD_W-1:0]  th,
  output logic              img_ren,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [7:0]        img_rdata,
  output logic              eng_ld,
  output logic [3:0]        eng_idx,
  output logic [7:0]        eng_px,
  output logic [PH_W-1:0]   eng_fx,
  output logic [PH_W-1:0]   eng_fy,
  output logic              eng_start,
  input  logic              eng_done,
  input  logic [7:0]        eng_result,
  output logic              res_wen,
  output logic [ADDR_W-1:0] res_addr,
  output logic [7:0]        res_wdata,
  output logic              busy,
  output logic              done
);

  if (ENG_TIMEOUT < 0) begin : g_chk
    $error("ENG_TIMEOUT must be non-negative");
  end

  state_t         r_state;
  crd_t           r_h0, r_v0, r_sw, r_sh, r_tw, r_th;
  crd_t           r_tx, r_ty, r_ix, r_iy;
  logic [CRD_W:0] r_nx, r_ny;
  logic [4:0]     r_cnt;
  logic           r_adv;
  addr_t          r_oaddr;

  crd_t            w_denx, w_deny, w_stpx, w_stpy;
  logic            w_dstart, w_dvalid, w_last;
  crd_t            w_dnum, w_dden;
  logic [PH_W-1:0] w_dq;
  logic [3:0]      w_tk;
  logic [8:0]      w_cs, w_rs;
  crd_t            w_col, w_row;
  addr_t           w_taddr;

  assign w_denx = r_tw - 7'd1;
  assign w_deny = r_th - 7'd1;
  // a single-pixel axis never steps
  assign w_stpx = (w_denx == '0) ? '0 : r_sw - 7'd1;
  assign w_stpy = (w_deny == '0) ? '0 : r_sh - 7'd1;
  assign w_last = (r_tx == w_denx) && (r_ty == w_deny);

  assign w_dstart = (r_state == DIV) && (r_cnt[2:0] == 3'd0);
  assign w_dnum   = r_cnt[3] ? r_ny[CRD_W-1:0] : r_nx[CRD_W-1:0];
  assign w_dden   = r_cnt[3] ? w_deny : w_denx;

  assign w_tk    = (r_state == DIV) ? 4'd0 : r_cnt[3:0] + 4'd1;
  assign w_cs    = 9'(r_h0) + 9'(r_ix) + 9'(w_tk[1:0]);
  assign w_rs    = 9'(r_v0) + 9'(r_iy) + 9'(w_tk[3:2]);
  assign w_col   = clamp(w_cs, IMG_W);
  assign w_row   = clamp(w_rs, IMG_H);
  assign w_taddr = addr_t'(w_row) * addr_t'(IMG_W) + addr_t'(w_col);

  assign busy   = (r_state != IDLE);
  assign eng_px = eng_ld ? img_rdata : 8'h00;

  bicubic_frac_div u_div (
    .clk   (clk),
    .rst_n (rst),
    .start (w_dstart),
    .num   (w_dnum),
    .den   (w_dden),
    .q     (w_dq),
    .valid (w_dvalid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      {r_h0, r_v0, r_sw, r_sh, r_tw, r_th} <= '0;
      {r_tx, r_ty, r_ix, r_iy} <= '0;
      r_nx <= '0; r_ny <= '0;
      r_cnt <= '0; r_adv <= 1'b0; r_oaddr <= '0;
      img_ren <= 1'b0; img_addr <= '0;
      eng_ld <= 1'b0; eng_idx <= '0;
      eng_fx <= '0; eng_fy <= '0; eng_start <= 1'b0;
      res_wen <= 1'b0; res_addr <= '0; res_wdata <= '0;
      done <= 1'b0;
    end else begin
      img_ren   <= 1'b0;
      eng_ld    <= 1'b0;
      eng_start <= 1'b0;
      res_wen   <= 1'b0;
      done      <= 1'b0;
      unique case (r_state)
        IDLE: if (start) r_state <= SETUP;
        SETUP: begin
          {r_h0, r_v0, r_sw, r_sh, r_tw, r_th} <= {h0, v0, sw, sh, tw, th};
          {r_tx, r_ty, r_ix, r_iy} <= '0;
          r_nx <= '0; r_ny <= '0;
          r_oaddr <= '0; r_cnt <= '0;
          r_state <= DIV;
        end
        DIV: begin
          r_cnt <= r_cnt + 5'd1;
          if (w_dvalid) eng_fx <= w_dq;
          if (r_cnt == 5'd15) begin
            r_cnt    <= '0;
            img_ren  <= 1'b1;
            img_addr <= w_taddr;
            r_state  <= FETCH;
          end
        end
        FETCH: begin
          r_cnt <= r_cnt + 5'd1;
          if (w_dvalid) eng_fy <= w_dq;
          if (r_cnt < 5'd15) begin
            img_ren  <= 1'b1;
            img_addr <= w_taddr;
          end
          if (r_cnt < 5'd16) begin
            eng_ld  <= 1'b1;
            eng_idx <= r_cnt[3:0];
          end else begin
            eng_start <= 1'b1;
            r_state   <= LAUNCH;
          end
        end
        LAUNCH: r_state <= WAIT;
        WAIT: if (eng_done) begin
          res_wen   <= 1'b1;
          res_wdata <= eng_result;
          res_addr  <= r_oaddr;
          r_state   <= WRITE;
        end
        WRITE: r_state <= NEXT;
        NEXT: begin
          if (!r_adv) begin
            r_adv   <= 1'b1;
            r_oaddr <= r_oaddr + 14'd1;
            if (w_last) begin
              r_adv   <= 1'b0;
              done    <= 1'b1;
              r_state <= FIN;
            end else if (r_tx == w_denx) begin
              r_tx <= '0; r_ix <= '0; r_nx <= '0;
              r_ty <= r_ty + 7'd1;
              r_ny <= r_ny + {1'b0, w_stpy};
            end else begin
              r_tx <= r_tx + 7'd1;
              r_nx <= r_nx + {1'b0, w_stpx};
            end
          // normalise one subtraction per cycle until both fractions fit
          end else if (w_denx != '0 && r_nx >= {1'b0, w_denx}) begin
            r_nx <= r_nx - {1'b0, w_denx};
            r_ix <= r_ix + 7'd1;
          end else if (w_deny != '0 && r_ny >= {1'b0, w_deny}) begin
            r_ny <= r_ny - {1'b0, w_deny};
            r_iy <= r_iy + 7'd1;
          end else begin
            r_adv   <= 1'b0;
            r_cnt   <= '0;
            r_state <= DIV;
          end
        end
        FIN: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bicubic_sched.sv
// tb_bicubic_sched: scoreboard bench with image memory and engine models
// for the bicubic tap scheduler.
module tb_bicubic_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  h0, v0, sw, sh, tw, th;
  logic        img_ren;
  logic [13:0] img_addr;
  logic [7:0]  img_rdata;
  logic        eng_ld;
  logic [3:0]  eng_idx;
  logic [7:0]  eng_px, eng_fx, eng_fy;
  logic        eng_start, eng_done;
  logic [7:0]  eng_result;
  logic        res_wen;
  logic [13:0] res_addr;
  logic [7:0]  res_wdata;
  logic        busy, done;

  int n_chk = 0;
  int n_fail = 0;
  int n_launch = 0;
  int n_done = 0;
  int eng_delay = 3;

  logic [7:0]  exp_fx_q[$], exp_fy_q[$], exp_d_q[$];
  logic [13:0] exp_a_q[$];
  logic [7:0]  obs_fx_q[$];
  logic [13:0] obs_ra_q[$];

  always #5 clk = ~clk;

  bicubic_sched dut (
    .clk(clk), .rst(rst), .start(start),
    .h0(h0), .v0(v0), .sw(sw), .sh(sh), .tw(tw), .th(th),
    .img_ren(img_ren), .img_addr(img_addr), .img_rdata(img_rdata),
    .eng_ld(eng_ld), .eng_idx(eng_idx), .eng_px(eng_px),
    .eng_fx(eng_fx), .eng_fy(eng_fy), .eng_start(eng_start),
    .eng_done(eng_done), .eng_result(eng_result),
    .res_wen(res_wen), .res_addr(res_addr), .res_wdata(res_wdata),
    .busy(busy), .done(done)
  );

  function automatic logic [7:0] mem(input int a);
    return 8'((a * 37) + (a >> 5));
  endfunction

  function automatic int clampi(input int x, input int lim);
    if (x < 0) return 0;
    if (x > lim - 1) return lim - 1;
    return x;
  endfunction

  // image memory, engine responder and output scoreboard
  initial begin : mon
    logic [7:0] acc, res, ef, ey, ed;
    logic [13:0] ea;
    int cnt;
    bit pend;
    acc = 0; res = 0; cnt = 0; pend = 0;
    eng_done = 0; eng_result = 0; img_rdata = 0;
    forever begin
      @(negedge clk);
      eng_done = 1'b0;
      if (!rst) begin
        acc = 0;
        pend = 0;
      end else begin
        if (eng_ld) acc = acc + (eng_px ^ {4'b0, eng_idx});
        if (img_ren) obs_ra_q.push_back(img_addr);
        if (eng_start) begin
          n_chk++;
          n_launch++;
          obs_fx_q.push_back(eng_fx);
          if (exp_fx_q.size() == 0) begin
            n_fail++;
            $display("FAIL launch_unexpected: fx=%0d fy=%0d, required no launch", eng_fx, eng_fy);
          end else begin
            ef = exp_fx_q.pop_front();
            ey = exp_fy_q.pop_front();
            if ({eng_fx, eng_fy} !== {ef, ey}) begin
              n_fail++;
              $display("FAIL launch_phase: fx=%0d fy=%0d, required fx=%0d fy=%0d", eng_fx, eng_fy, ef, ey);
            end
          end
          res = acc; acc = 0; pend = 1; cnt = eng_delay;
        end else if (pend) begin
          cnt--;
          if (cnt == 0) begin
            eng_done = 1'b1;
            eng_result = res;
            pend = 0;
          end
        end
        if (res_wen) begin
          n_chk++;
          if (exp_a_q.size() == 0 || pend) begin
            n_fail++;
            $display("FAIL write_unexpected: addr=%0d data=%0d pend=%0d, required no write", res_addr, res_wdata, pend);
          end else begin
            ea = exp_a_q.pop_front();
            ed = exp_d_q.pop_front();
            if ({res_addr, res_wdata} !== {ea, ed}) begin
              n_fail++;
              $display("FAIL write_result: addr=%0d data=%0d, required addr=%0d data=%0d", res_addr, res_wdata, ea, ed);
            end
          end
        end
        if (done) n_done++;
      end
      img_rdata = (rst && img_ren) ? mem(int'(img_addr)) : 8'h00;
    end
  end

  task automatic push_job(input int h, v, s_w, s_h, t_w, t_h);
    int ix, nx, iy, ny, fx, fy, sum, col, row;
    for (int ty = 0; ty < t_h; ty++) begin
      for (int tx = 0; tx < t_w; tx++) begin
        ix = 0; nx = 0; iy = 0; ny = 0;
        if (t_w > 1) begin
          ix = tx * (s_w - 1) / (t_w - 1);
          nx = tx * (s_w - 1) % (t_w - 1);
        end
        if (t_h > 1) begin
          iy = ty * (s_h - 1) / (t_h - 1);
          ny = ty * (s_h - 1) % (t_h - 1);
        end
        fx = (t_w > 1) ? nx * 256 / (t_w - 1) : 0;
        fy = (t_h > 1) ? ny * 256 / (t_h - 1) : 0;
        sum = 0;
        for (int k = 0; k < 16; k++) begin
          col = clampi(h + ix + (k % 4) - 1, 100);
          row = clampi(v + iy + (k / 4) - 1, 100);
          sum = sum + int'(mem(row * 100 + col) ^ 8'(k));
        end
        exp_fx_q.push_back(8'(fx));
        exp_fy_q.push_back(8'(fy));
        exp_a_q.push_back(14'(ty * t_w + tx));
        exp_d_q.push_back(8'(sum));
      end
    end
  endtask

  task automatic run_job(input int h, v, s_w, s_h, t_w, t_h,
                         input int dly, input bit inject, input string nm);
    int budget, wc;
    bit injected;
    wc = 0; injected = 0;
    push_job(h, v, s_w, s_h, t_w, t_h);
    eng_delay = dly;
    n_launch = 0; n_done = 0;
    obs_fx_q.delete(); obs_ra_q.delete();
    @(negedge clk);
    h0 = 7'(h); v0 = 7'(v); sw = 7'(s_w); sh = 7'(s_h);
    tw = 7'(t_w); th = 7'(t_h);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    budget = 300 * t_w * t_h + 200;
    while (n_done == 0 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (inject && !injected && n_launch == 1) begin
        wc++;
        if (wc == 5) begin
          start = 1'b1;
          h0 = 0; v0 = 0; tw = 1; th = 1;
          injected = 1;
          n_chk++;
          if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_busy: busy=%b, required 1", nm, busy);
          end
        end
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    n_chk++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL %s_timeout: done count=%0d, required done within bound", nm, n_done);
    end
    repeat (40) @(negedge clk);
    n_chk++;
    if (n_done !== 1 || n_launch !== t_w * t_h) begin
      n_fail++;
      $display("FAIL %s_count: done=%0d launches=%0d, required done=1 launches=%0d", nm, n_done, n_launch, t_w * t_h);
    end
    n_chk++;
    if (exp_a_q.size() != 0 || exp_fx_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: writes left=%0d launches left=%0d busy=%b, required 0 0 0", nm, exp_a_q.size(), exp_fx_q.size(), busy);
    end
    exp_fx_q.delete(); exp_fy_q.delete();
    exp_a_q.delete(); exp_d_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0;
    h0 = 0; v0 = 0; sw = 1; sh = 1; tw = 1; th = 1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({img_ren, img_addr, eng_ld, eng_idx, eng_px, eng_fx, eng_fy, eng_start,
         res_wen, res_addr, res_wdata, busy, done} !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ren=%b addr=%0d ld=%b start=%b wen=%b busy=%b done=%b, required all 0",
               img_ren, img_addr, eng_ld, eng_start, res_wen, busy, done);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_unity();
    run_job(10, 10, 4, 4, 4, 4, 3, 0, "unity");
  endtask

  task automatic test_dda();
    logic [13:0] ra[3];
    logic [13:0] ea[3];
    int ri[3];
    run_job(20, 20, 4, 1, 7, 1, 2, 0, "dda");
    n_chk++;
    if (obs_fx_q.size() < 7) begin
      n_fail++;
      $display("FAIL dda_fx_count: got %0d phases, required 7", obs_fx_q.size());
    end else if ({obs_fx_q[1], obs_fx_q[2], obs_fx_q[6]} !== {8'd128, 8'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL dda_fx: tx1=%0d tx2=%0d tx6=%0d, required 128 0 0", obs_fx_q[1], obs_fx_q[2], obs_fx_q[6]);
    end
    ri = '{21, 37, 101};
    ea = '{14'd2020, 14'd2021, 14'd2023};
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      ra[i] = (obs_ra_q.size() > ri[i]) ? obs_ra_q[ri[i]] : 14'h3fff;
      if (ra[i] !== ea[i]) begin
        n_fail++;
        $display("FAIL dda_ix_addr%0d: addr=%0d, required %0d", i, ra[i], ea[i]);
      end
    end
  endtask

  task automatic test_clamp();
    logic [13:0] e4[4];
    e4 = '{14'd0, 14'd0, 14'd1, 14'd2};
    run_job(0, 0, 2, 2, 2, 2, 1, 0, "clamp_lo");
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (obs_ra_q.size() <= i || obs_ra_q[i] !== e4[i]) begin
        n_fail++;
        $display("FAIL clamp_addr%0d: addr=%0d, required %0d", i,
                 (obs_ra_q.size() > i) ? obs_ra_q[i] : 14'h3fff, e4[i]);
      end
    end
    run_job(98, 98, 2, 2, 3, 3, 4, 0, "clamp_hi");
  endtask

  task automatic test_scale();
    run_job(0, 0, 100, 100, 3, 3, 2, 0, "down");
    run_job(40, 50, 9, 5, 5, 3, 5, 0, "mixed");
  endtask

  task automatic test_busy_start();
    run_job(30, 30, 3, 2, 3, 2, 20, 1, "busy_start");
  endtask

  task automatic test_reset_mid();
    int budget, wens;
    push_job(30, 30, 3, 3, 4, 4);
    eng_delay = 3; n_launch = 0;
    @(negedge clk);
    h0 = 30; v0 = 30; sw = 3; sh = 3; tw = 4; th = 4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    budget = 2000;
    while (!(n_launch == 3 && img_ren) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_chk++;
    if (budget == 0) begin
      n_fail++;
      $display("FAIL rmid_reach: launches=%0d, required fetch of pixel 3", n_launch);
    end
    rst = 1'b0;
    #1;
    exp_fx_q.delete(); exp_fy_q.delete();
    exp_a_q.delete(); exp_d_q.delete();
    n_chk++;
    if ({img_ren, img_addr, eng_ld, eng_idx, eng_px, eng_fx, eng_fy, eng_start,
         res_wen, res_addr, res_wdata, busy, done} !== 70'd0) begin
      n_fail++;
      $display("FAIL rmid_outputs: ren=%b addr=%0d ld=%b wen=%b busy=%b, required all 0",
               img_ren, img_addr, eng_ld, res_wen, busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wens = 0;
    repeat (60) begin
      @(negedge clk);
      if (res_wen || busy) wens++;
    end
    n_chk++;
    if (wens !== 0) begin
      n_fail++;
      $display("FAIL rmid_idle: active cycles=%0d, required 0", wens);
    end
    run_job(5, 5, 1, 1, 1, 1, 2, 0, "rmid_single");
  endtask

  initial begin
    test_reset();
    test_unity();
    test_dda();
    test_clamp();
    test_scale();
    test_busy_start();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
